// File: rtl/max7219_spi_frame_tx.sv
// Serialises one MAX7219 command word (address byte + data byte, MSB first)
// onto DIN/CLK/LOAD. The pin clock is gated from the free-running divider
// clock, so the device sees exactly WORD_W rising edges per frame. DIN only
// changes on falling sck edges, which gives the device a half period of setup
// and hold around each sampling edge.
module max7219_spi_frame_tx #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              sck_edge,
  input  logic              start,
  input  logic [WORD_W-1:0] data,
  output logic              din,
  output logic              sck_out,
  output logic              load,
  output logic              busy,
  output logic              done
);

  // The counter must be able to hold WORD_W itself (16 edges counted).
  localparam int CNT_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              sck_q;
  logic              din_q, din_d;
  logic              load_q, load_d;
  logic              done_q, done_d;
  logic              sck_fall;

  // Falling edge of the divider clock, seen one clk after sck drops.
  assign sck_fall = sck_q & ~sck;

  // State register and registered pin outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      sck_q    <= 1'b0;
      din_q    <= 1'b0;
      load_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sck_q    <= sck;
      din_q    <= din_d;
      load_q   <= load_d;
      done_q   <= done_d;
    end
  end

  // Next-state and shift/count logic for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    din_d    = din_q;
    load_d   = load_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        load_d = 1'b1;
        din_d  = 1'b0;
        if (start) begin
          shreg_d = data;
          state_d = ALIGN;
        end
      end

      // Wait for a falling sck so the first bit gets a full low half period
      // of setup before the first gated rising edge.
      ALIGN: begin
        if (sck_fall) begin
          load_d   = 1'b0;
          din_d    = shreg_q[WORD_W-1];
          shreg_d  = shreg_q << 1;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (sck_edge) begin
          bitcnt_d = bitcnt_q + CNT_W'(1);
        end
        // Shift decision uses the count from before any same-cycle increment.
        if (sck_fall) begin
          if (bitcnt_q < CNT_W'(WORD_W)) begin
            din_d   = shreg_q[WORD_W-1];
            shreg_d = shreg_q << 1;
          end else begin
            load_d  = 1'b1;
            din_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign din     = din_q;
  assign load    = load_q;
  assign done    = done_q;
  assign sck_out = sck & (state_q == SHIFT);
  // busy covers the done cycle too, even though the FSM is already in IDLE.
  assign busy    = (state_q != IDLE) | done_q;

endmodule

// File: doc/max7219_spi_frame_tx.md
# max7219_spi_frame_tx

Serialises one 16-bit MAX7219 command word (address byte + data byte, MSB first) onto the DIN/CLK/LOAD pins. It consumes the free-running serial clock level and its rising-edge strobe produced by the SCK divider stage upstream, and is itself driven by the display-sequencer FSM through a start/busy/done handshake. It gates the pin clock so that exactly 16 rising edges reach the device per frame. It raises LOAD after the 16th edge to latch the word.

## Interface
Parameters:
- WORD_W, 16, frame length in bits; MAX7219 requires 16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sck  input  1  free-running serial clock level from the divider; low after reset.
- sck_edge  input  1  one-cycle strobe, high in the first clk cycle of each sck high phase.
- start  input  1  one-cycle request; sampled only in IDLE.
- data  input  WORD_W  word to send; [15:8] register address, [7:0] value; captured on accepted start.
- din  output  1  serial data to MAX7219 DIN.
- sck_out  output  1  gated pin clock to MAX7219 CLK: sck AND (state==SHIFT).
- load  output  1  MAX7219 LOAD/CS; low for the duration of a frame.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse when the frame is latched.

## Operation
- Internal registers: state, shreg[WORD_W-1:0], bitcnt[4:0] (0..16), sck_q (previous sck).
- sck_fall = sck_q & ~sck, computed combinationally from registered sck_q.
- States: IDLE, ALIGN, SHIFT.
- IDLE: load=1, din=0, busy=0. On start=1: shreg<=data, state<=ALIGN. start is ignored in every other state.
- ALIGN: busy=1, load=1. Waits for sck_fall. On sck_fall: load<=0, din<=shreg[WORD_W-1], shreg<=shreg<<1, bitcnt<=0, state<=SHIFT. sck_edge is ignored in ALIGN.
- SHIFT: busy=1, load=0, sck_out follows sck.
  - On sck_edge: bitcnt<=bitcnt+1. The device samples din here.
  - On sck_fall with bitcnt<WORD_W: din<=shreg[WORD_W-1], shreg<=shreg<<1.
  - On sck_fall with bitcnt==WORD_W: load<=1, din<=0, done<=1 for one cycle, state<=IDLE.
- din changes only at sck falling edges, which gives a half-period of setup and hold around each device sampling edge.
- Back-to-back: a start in the cycle after done is accepted. The new frame waits in ALIGN for the next sck_fall, so LOAD stays high for at least one sck period between frames.
- Reset (asynchronous, any time, including mid-frame):
  - Outputs: load=1, din=0, sck_out=0, busy=0, done=0.
  - Registers: state=IDLE, bitcnt=0, shreg=0, sck_q=0.
  - A partially shifted frame is discarded. LOAD rises without 16 edges, so the device does not latch meaningful data.

## Timing
- start to busy: 1 cycle.
- start to load falling: wait for the first sck_fall after ALIGN is entered (0 to 1 sck period), plus 1 cycle.
- Frame duration: from the aligning fall F0 to the latching fall F16 is exactly 16 sck periods.
- done and load rise are asserted in the same cycle, 1 clk after the sck_fall that follows the 16th counted sck_edge.
- sck_out shows exactly WORD_W rising edges per frame and none outside SHIFT.
- Simultaneous sck_edge and sck_fall cannot occur, because they come from opposite sck levels.
- If they did occur, the bitcnt increment applies and the shift is still evaluated against the pre-increment count.

## Test plan
Bench sck: period 10 clk, 5 low then 5 high, with sck_edge in the first high cycle.
- Reset mid-pattern, then release: load=1, din=0, busy=0, done=0, and sck_out=0 through several sck periods.
- Single frame, data=16'h0C01:
  - din sampled at each sck_out rise reads 0000_1100_0000_0001 in order.
  - Exactly 16 sck_out rises occur.
  - load low across all of them.
  - done occurs once, 160 clk after load falls.
- Single frame, data=16'hFFFF and then 16'h0000: all sampled bits match, and din never changes while sck=1.
- Back-to-back: start=16'h0A0F asserted in the done cycle of the previous frame.
  - The new frame is accepted.
  - load stays high for ≥10 clk between frames.
  - Both words are received intact.
- start pulses while busy (data=16'hDEAD): ignored; the transmitted word is unchanged and only one done occurs.
- rst_n asserted after the 7th sck_out rise:
  - load=1, sck_out=0, busy=0 immediately.
  - A subsequent start sends a full, correct 16-bit frame.
